// File: rtl/axi_xbar_pkg.sv
// axi_xbar_pkg: shared demux state encoding and ID/select types.
package axi_xbar_pkg;
  localparam int unsigned AxiIdBits = 3;
  localparam int unsigned SelWidth  = 2;
  typedef logic [AxiIdBits-1:0] id_t;
  typedef logic [SelWidth-1:0]  sel_t;
  typedef enum logic [1:0] {EMPTY, CHECK, STALL, ISSUE} state_e;
endpackage

// File: rtl/axi_sat_counter.sv
// axi_sat_counter: up-counter that sticks at all-ones instead of wrapping.
module axi_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] r_cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_cnt <= '0;
    else if (en_i && ~&r_cnt) r_cnt <= r_cnt + Width'(1);
  assign cnt_o = r_cnt;
endmodule

// File: rtl/axi_demux_ax_id_gate.sv
// axi_demux_ax_id_gate: holds one AW/AR request until its ID may go to the selected master.
// Optional AXI_ID_GATE_ATOP_EN also blocks atomics whose ID is live on the read side.
module axi_demux_ax_id_gate
  import axi_xbar_pkg::*;
#(
  parameter int unsigned MaxTrans   = 8,
  parameter int unsigned CntWidth   = 4,
  parameter int unsigned StallWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_valid_i,
  output logic                  slv_ready_o,
  input  id_t                   slv_id_i,
  input  sel_t                  slv_sel_i,
  input  logic                  slv_atop_i,
  output logic                  mst_valid_o,
  input  logic                  mst_ready_i,
  output id_t                   mst_id_o,
  output sel_t                  mst_sel_o,
  output id_t                   lookup_id_o,
  input  logic                  lookup_taken_i,
  input  sel_t                  lookup_sel_i,
  input  logic                  atop_taken_i,
  input  logic [CntWidth-1:0]   in_flight_cnt_i,
  output logic                  push_en_o,
  output id_t                   push_id_o,
  output sel_t                  push_sel_o,
  output logic [StallWidth-1:0] stall_cnt_o
);
  state_e r_state, w_next;
  id_t    r_id;
  sel_t   r_sel;
  logic   w_ok, w_base_ok, w_slv_hs, w_mst_hs;
  assign slv_ready_o = (r_state == EMPTY) || (r_state == ISSUE && mst_ready_i);
  assign mst_valid_o = r_state == ISSUE;
  assign w_slv_hs    = slv_valid_i && slv_ready_o;
  assign w_mst_hs    = mst_valid_o && mst_ready_i;
  assign w_base_ok   = (!lookup_taken_i || lookup_sel_i == r_sel) && (in_flight_cnt_i < CntWidth'(MaxTrans));
`ifdef AXI_ID_GATE_ATOP_EN
  logic r_atop;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_atop <= 1'b0;
    else if (w_slv_hs) r_atop <= slv_atop_i;
  assign w_ok = w_base_ok && !(r_atop && atop_taken_i);
`else
  logic w_unused;
  assign w_unused = slv_atop_i ^ atop_taken_i;
  assign w_ok     = w_base_ok;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= EMPTY;
      r_id    <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (w_slv_hs) begin
        r_id  <= slv_id_i;
        r_sel <= slv_sel_i;
      end
    end
  // ISSUE never drops valid on its own; only the downstream handshake leaves it
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:        w_next = w_slv_hs ? CHECK : EMPTY;
      CHECK, STALL: w_next = w_ok ? ISSUE : STALL;
      ISSUE:        w_next = w_mst_hs ? (w_slv_hs ? CHECK : EMPTY) : ISSUE;
      default:      w_next = EMPTY;
    endcase
  end
  assign mst_id_o    = r_id;
  assign mst_sel_o   = r_sel;
  assign lookup_id_o = r_id;
  assign push_en_o   = w_mst_hs;
  assign push_id_o   = r_id;
  assign push_sel_o  = r_sel;
  axi_sat_counter #(.Width(StallWidth)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (r_state == STALL),
    .cnt_o (stall_cnt_o)
  );
endmodule

// File: tb/tb_axi_demux_ax_id_gate.sv
// tb_axi_demux_ax_id_gate: directed and random checks against a request-level reference model.
module tb_axi_demux_ax_id_gate;
  localparam int MaxTrans = 8, CntWidth = 4, StallWidth = 16;
  localparam int SatMax = (1 << StallWidth) - 1;
`ifdef AXI_ID_GATE_ATOP_EN
  localparam bit AtopEn = 1'b1;
`else
  localparam bit AtopEn = 1'b0;
`endif
  logic clk = 1'b0, rst_i;
  logic slv_valid_i, slv_ready_o, slv_atop_i, mst_valid_o, mst_ready_i;
  logic lookup_taken_i, atop_taken_i, push_en_o;
  logic [2:0] slv_id_i, mst_id_o, lookup_id_o, push_id_o;
  logic [1:0] slv_sel_i, mst_sel_o, lookup_sel_i, push_sel_o;
  logic [CntWidth-1:0] in_flight_cnt_i;
  logic [StallWidth-1:0] stall_cnt_o;
  int total = 0, bad = 0;
  bit m_have, m_granted, m_atop;
  int m_age, m_stall, s0;
  logic [2:0] m_id;
  logic [1:0] m_sel;
  always #5 clk = ~clk;
  axi_demux_ax_id_gate #(.MaxTrans(MaxTrans), .CntWidth(CntWidth), .StallWidth(StallWidth)) dut (
    .clk_i(clk), .rst_i(rst_i), .slv_valid_i(slv_valid_i), .slv_ready_o(slv_ready_o),
    .slv_id_i(slv_id_i), .slv_sel_i(slv_sel_i), .slv_atop_i(slv_atop_i),
    .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i), .mst_id_o(mst_id_o), .mst_sel_o(mst_sel_o),
    .lookup_id_o(lookup_id_o), .lookup_taken_i(lookup_taken_i), .lookup_sel_i(lookup_sel_i),
    .atop_taken_i(atop_taken_i), .in_flight_cnt_i(in_flight_cnt_i), .push_en_o(push_en_o),
    .push_id_o(push_id_o), .push_sel_o(push_sel_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit ok();
    bit r = (!lookup_taken_i || lookup_sel_i == m_sel) && (int'(in_flight_cnt_i) < MaxTrans);
    return r && !(AtopEn && m_atop && atop_taken_i);
  endfunction
  task automatic model_clear();
    m_have = 0; m_granted = 0; m_atop = 0; m_age = 0; m_stall = 0; m_id = 0; m_sel = 0;
  endtask
  task automatic idle();
    slv_valid_i = 0; slv_id_i = 0; slv_sel_i = 0; slv_atop_i = 0; mst_ready_i = 1;
    lookup_taken_i = 0; lookup_sel_i = 0; atop_taken_i = 0; in_flight_cnt_i = 0;
  endtask
  // one clock: compare outputs for the current inputs, then advance the model past the edge
  task automatic cyc();
    bit v, r, hs_s, hs_m;
    #1;
    v = m_have && m_granted;
    r = !m_have || (v && mst_ready_i);
    chk("valid", mst_valid_o, v);
    chk("ready", slv_ready_o, r);
    chk("push_en", push_en_o, v && mst_ready_i);
    chk("id", mst_id_o, m_id);
    chk("sel", mst_sel_o, m_sel);
    chk("lookup_id", lookup_id_o, m_id);
    chk("push_id", push_id_o, m_id);
    chk("push_sel", push_sel_o, m_sel);
    chk("stall_cnt", stall_cnt_o, m_stall);
    hs_s = slv_valid_i && r;
    hs_m = v && mst_ready_i;
    if (hs_s) begin
      m_have = 1; m_granted = 0; m_age = 1;
      m_id = slv_id_i; m_sel = slv_sel_i; m_atop = slv_atop_i;
    end else if (hs_m) m_have = 0;
    else if (m_have && !m_granted) begin
      if (m_age >= 2 && m_stall < SatMax) m_stall++;
      if (ok()) m_granted = 1;
      m_age++;
    end
    @(negedge clk);
  endtask
  task automatic load(input logic [2:0] id, input logic [1:0] sel);
    slv_valid_i = 1; slv_id_i = id; slv_sel_i = sel;
    cyc();
    slv_valid_i = 0;
    cyc();
  endtask
  initial begin
    idle();
    model_clear();
    rst_i = 1;
    @(negedge clk);
    chk("rst_ready", slv_ready_o, 1);
    chk("rst_valid", mst_valid_o, 0);
    chk("rst_id", mst_id_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    @(negedge clk);
    rst_i = 0;
    cyc();
    load(3'd3, 2'd1);
    #1;
    chk("t2_valid", mst_valid_o, 1);
    chk("t2_push_en", push_en_o, 1);
    chk("t2_push_id", push_id_o, 3);
    chk("t2_push_sel", push_sel_o, 1);
    cyc();
    lookup_taken_i = 1; lookup_sel_i = 2'd1;
    load(3'd2, 2'd0);
    s0 = int'(stall_cnt_o);
    repeat (4) cyc();
    lookup_taken_i = 0;
    cyc();
    #1;
    chk("t3_valid", mst_valid_o, 1);
    chk("t3_stall", int'(stall_cnt_o) - s0, 5);
    cyc();
    lookup_taken_i = 1; lookup_sel_i = 2'd1;
    load(3'd2, 2'd1);
    #1;
    chk("t4_valid", mst_valid_o, 1);
    cyc();
    idle();
    load(3'd5, 2'd2);
    mst_ready_i = 0; lookup_taken_i = 1; lookup_sel_i = 2'd0; in_flight_cnt_i = 4'd8;
    repeat (4) begin
      #1;
      chk("t6_valid", mst_valid_o, 1);
      chk("t6_id", mst_id_o, 5);
      chk("t6_sel", mst_sel_o, 2);
      cyc();
    end
    idle();
    cyc();
    slv_atop_i = 1; atop_taken_i = 1;
    load(3'd6, 2'd3);
    #1;
    chk("atop_valid", mst_valid_o, !AtopEn);
    idle();
    repeat (3) cyc();
    in_flight_cnt_i = 4'd8;
    load(3'd1, 2'd0);
    #1;
    chk("t5_stall_valid", mst_valid_o, 0);
    repeat (SatMax + 11) cyc();
    chk("t5_sat", stall_cnt_o, SatMax);
    in_flight_cnt_i = 4'd7;
    cyc();
    #1;
    chk("t5_valid", mst_valid_o, 1);
    mst_ready_i = 0;
    cyc();
    rst_i = 1; mst_ready_i = 1;
    #1;
    chk("t1_valid", mst_valid_o, 0);
    chk("t1_ready", slv_ready_o, 1);
    chk("t1_push_en", push_en_o, 0);
    chk("t1_stall", stall_cnt_o, 0);
    model_clear();
    @(negedge clk);
    rst_i = 0;
    repeat (2000) begin
      slv_valid_i = 1'($urandom_range(0, 1));
      slv_id_i = 3'($urandom);
      slv_sel_i = 2'($urandom);
      slv_atop_i = 1'($urandom_range(0, 1));
      mst_ready_i = $urandom_range(0, 3) != 0;
      lookup_taken_i = 1'($urandom_range(0, 1));
      lookup_sel_i = 2'($urandom);
      atop_taken_i = $urandom_range(0, 3) == 0;
      in_flight_cnt_i = 4'($urandom_range(0, 9));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
